// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential MULT/DIV unit:
// op codes, shared-ALU signal codes and FSM states.
package muldiv_seq_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS_A,
      S_ABS_B,
      S_ITER,
      S_FIX_LO,
      S_FIX_HI,
      S_DONE
   } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared EX ALU
// (shift-add multiply, restoring divide, one ALU op per cycle).
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_signal,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, p_q, q_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q, negr_q, dbz_q;
   logic             busy_q, done_q, dbzo_q;

   logic             is_div, is_sgn, q_zero;
   logic [WIDTH-1:0] rem_s, sum, abs_x;
   logic             top, carry, borrow, ok;
   logic [WIDTH-1:0] p_d, q_d;

   assign is_div = op_q[1];
   assign is_sgn = op_q[0];
   assign q_zero = (q_q == '0);

   // Divide works on the 33-bit partial remainder {top, rem_s}
   assign rem_s = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign top   = p_q[WIDTH-1];

   assign sum   = q_q[0] ? alu_result : p_q;
   assign carry = q_q[0] &
                  ((p_q[WIDTH-1] & a_q[WIDTH-1]) |
                   ((p_q[WIDTH-1] ^ a_q[WIDTH-1]) &
                    ~alu_result[WIDTH-1]));

   assign borrow = (~rem_s[WIDTH-1] & b_q[WIDTH-1]) |
                   (~(rem_s[WIDTH-1] ^ b_q[WIDTH-1]) &
                    alu_result[WIDTH-1]);
   assign ok     = top | ~borrow;

   assign p_d = is_div ? (ok ? alu_result : rem_s)
                       : {carry, sum[WIDTH-1:1]};
   assign q_d = is_div ? {q_q[WIDTH-2:0], ok}
                       : {sum[0], q_q[WIDTH-1:1]};

   assign abs_x = (state_q == S_ABS_A)
                ? (a_q[WIDTH-1] ? alu_result : a_q)
                : (b_q[WIDTH-1] ? alu_result : b_q);

   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_signal = ALU_ADD;
      unique case (state_q)
         S_ABS_A: begin
            alu_b      = a_q;
            alu_signal = ALU_SUB;
         end
         S_ABS_B: begin
            alu_b      = b_q;
            alu_signal = ALU_SUB;
         end
         S_ITER: begin
            if (is_div) begin
               alu_a      = rem_s;
               alu_b      = b_q;
               alu_signal = ALU_SUB;
            end else begin
               alu_a = p_q;
               alu_b = a_q;
            end
         end
         S_FIX_LO: begin
            if (neg_q) begin
               alu_b      = q_q;
               alu_signal = ALU_SUB;
            end
         end
         S_FIX_HI: begin
            if (!is_div && neg_q) begin
               alu_a = ~p_q;
               alu_b = {{(WIDTH-1){1'b0}}, q_zero};
            end else if (is_div && negr_q) begin
               alu_b      = p_q;
               alu_signal = ALU_SUB;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         q_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbzo_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  busy_q <= 1'b0;
                  // busy_q still high here means this is the done cycle
                  if (start && !busy_q) begin
                     op_q   <= op;
                     a_q    <= src_a;
                     b_q    <= src_b;
                     neg_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                     negr_q <= src_a[WIDTH-1];
                     cnt_q  <= CNT_W'(WIDTH - 1);
                     busy_q <= 1'b1;
                     dbz_q  <= 1'b0;
                     p_q    <= '0;
                     q_q    <= op[1] ? src_a : src_b;
                     if (op[1] && src_b == '0) begin
                        dbz_q   <= 1'b1;
                        p_q     <= src_a;
                        q_q     <= '1;
                        state_q <= S_DONE;
                     end else if (op[0]) begin
                        state_q <= S_ABS_A;
                     end else begin
                        state_q <= S_ITER;
                     end
                  end
               end
               S_ABS_A: begin
                  a_q     <= abs_x;
                  state_q <= S_ABS_B;
               end
               S_ABS_B: begin
                  b_q     <= abs_x;
                  q_q     <= is_div ? a_q : abs_x;
                  state_q <= S_ITER;
               end
               S_ITER: begin
                  p_q   <= p_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     state_q <= is_sgn ? S_FIX_LO : S_DONE;
                  end
               end
               S_FIX_LO: begin
                  if (neg_q) q_q <= alu_result;
                  state_q <= S_FIX_HI;
               end
               S_FIX_HI: begin
                  if (is_div ? negr_q : neg_q) p_q <= alu_result;
                  state_q <= S_DONE;
               end
               S_DONE: begin
                  hi_q    <= p_q;
                  lo_q    <= q_q;
                  dbzo_q  <= dbz_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbzo_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected
// hi/lo/div_by_zero/done-cycle, a negedge monitor pops on done.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_signal;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
      int          tag;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
      .alu_result(alu_result), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Shared EX ALU stand-in
   always_comb begin
      alu_result = '0;
      case (alu_signal)
         3'b000: alu_result = alu_a & alu_b;
         3'b001: alu_result = alu_a | alu_b;
         3'b010: alu_result = alu_a + alu_b;
         3'b110: alu_result = alu_a - alu_b;
         3'b111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("hi_op%0d", e.tag), hi, e.hi);
            chk($sformatf("lo_op%0d", e.tag), lo, e.lo);
            chk($sformatf("dbz_op%0d", e.tag), {31'b0, div_by_zero},
                {31'b0, e.dbz});
            chk($sformatf("latency_op%0d", e.tag), 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic run_op(input int tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input int lat,
                         input bit chk_busy, input bit poke);
      exp_t e;
      int   i;
      @(negedge clk);
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.cyc = cyc + 1 + lat; e.tag = tag;
      q.push_back(e);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      i = 0;
      while (q.size() != 0 && i < lat + 5) begin
         if (chk_busy && i < lat)
            chk($sformatf("busy_op%0d_c%0d", tag, i), {31'b0, busy}, 32'd1);
         if (poke && i == 5) begin
            op = 2'b10; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
         end
         if (poke && i == 6) start = 1'b0;
         @(negedge clk);
         i++;
      end
      start = 1'b0;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_op%0d actual=no_done required=done", tag);
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_op(1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1, 1'b0);
      run_op(2, 2'b01, 32'hFFFFFFFD, 32'h00000007,
             32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 37, 1'b0, 1'b1);
      run_op(3, 2'b10, 32'd100, 32'd7,
             32'h00000002, 32'h0000000E, 1'b0, 33, 1'b0, 1'b0);
      run_op(4, 2'b11, 32'hFFFFFFF9, 32'h00000002,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 37, 1'b0, 1'b0);
      run_op(5, 2'b11, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000, 1'b0, 37, 1'b0, 1'b0);
      run_op(6, 2'b10, 32'd5, 32'd0,
             32'h00000005, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 1'b0);
      run_op(7, 2'b01, 32'h00000006, 32'hFFFFFFFE,
             32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 37, 1'b0, 1'b0);

      // start asserted in the done cycle must be dropped
      begin
         exp_t e;
         @(negedge clk);
         e.hi = 32'd9; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
         e.cyc = cyc + 2; e.tag = 8;
         q.push_back(e);
         op = 2'b10; src_a = 32'd9; src_b = 32'd0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_in_done_busy", {31'b0, busy}, 32'd0);
         chk("op8_popped", 32'(q.size()), 32'd0);
         repeat (40) @(negedge clk);
      end

      // flush mid-ITER: no done, results untouched
      dc = done_cnt;
      @(negedge clk);
      op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("busy_before_flush", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_hi", hi, 32'd9);
      chk("flush_lo", lo, 32'hFFFFFFFF);
      chk("flush_dbz", {31'b0, div_by_zero}, 32'd1);
      repeat (40) @(negedge clk);
      chk("flush_no_done", 32'(done_cnt), 32'(dc));

      // reset in the middle of ITER
      @(negedge clk);
      op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_hi", hi, 32'h0);
      chk("mid_rst_lo", lo, 32'h0);
      chk("mid_rst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
      chk("mid_rst_alu_a", alu_a, 32'h0);
      chk("mid_rst_alu_b", alu_b, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_no_done", 32'(done_cnt), 32'(dc));
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
